// File: rtl/wb_arbiter_n.sv
// wb_arbiter_n -- N-port Wishbone classic arbiter with cycle-locked grants.
//
// Several masters share one slave bus, such as the cache or SDRAM controller
// input. A grant is taken from IDLE one cycle after a request. It is held for
// as long as the owner keeps m_cyc_i high, so block transfers stay atomic.
// After the owner releases the bus there is always one dead cycle in IDLE.
// RR=1 selects round-robin arbitration, which starts scanning after the last
// owner. RR=0 selects fixed priority, where the lowest requesting index wins.
//
// Optional build macro: ARB_TIMEOUT_EN
//   When this macro is defined, a watchdog counts stalled strobe cycles. When
//   the count reaches TIMEOUT-1 it pulses m_err_o[owner] for one cycle. The
//   slave bus is then parked until the owner drops m_cyc_i.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i   per-master controls, one bit per port
//   m_sel_i/m_adr_i/m_dat_i  per-master fields, flattened with port k at slice k
//   m_dat_o             read data, broadcast from s_dat_i
//   m_ack_o/m_err_o     per-master termination, driven only for the owner
//   s_cyc_o .. s_dat_o  slave bus, passed through from the owner while OWNED
//   s_dat_i/s_ack_i/s_err_i  slave responses
//   owner_o             current or most recent owner index
//   busy_o              a grant is active
module wb_arbiter_n #(
    parameter int NPORTS  = 2,
    parameter int AWIDTH  = 26,
    parameter int DWIDTH  = 32,
    parameter int RR      = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NPORTS-1:0]               m_cyc_i,
    input  logic [NPORTS-1:0]               m_stb_i,
    input  logic [NPORTS-1:0]               m_we_i,
    input  logic [NPORTS*(DWIDTH/8)-1:0]    m_sel_i,
    input  logic [NPORTS*AWIDTH-1:0]        m_adr_i,
    input  logic [NPORTS*DWIDTH-1:0]        m_dat_i,
    output logic [DWIDTH-1:0]               m_dat_o,
    output logic [NPORTS-1:0]               m_ack_o,
    output logic [NPORTS-1:0]               m_err_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [DWIDTH/8-1:0]             s_sel_o,
    output logic [AWIDTH-1:0]               s_adr_o,
    output logic [DWIDTH-1:0]               s_dat_o,
    input  logic [DWIDTH-1:0]               s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    output logic [((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0] owner_o,
    output logic                            busy_o
);

    localparam int SW = DWIDTH / 8;
    localparam int OW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    if (NPORTS < 1 || NPORTS > 16) begin : g_bad_nports
        $error("wb_arbiter_n: NPORTS must be 1..16");
    end
    if ((DWIDTH % 8) != 0) begin : g_bad_dwidth
        $error("wb_arbiter_n: DWIDTH must be a multiple of 8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_arbiter_n: TIMEOUT must be at least 2");
    end

    // ABORT is reachable only when the watchdog is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last;
    logic [OW-1:0]   winner;
    logic            found;
    int              scan_idx;

    logic              own_cyc;
    logic              own_stb;
    logic              own_we;
    logic [SW-1:0]     own_sel;
    logic [AWIDTH-1:0] own_adr;
    logic [DWIDTH-1:0] own_dat;
    logic              timeout_hit;

    // Winner selection. Round-robin scans last+1, last+2, ... modulo NPORTS.
    // Fixed priority scans from index 0 upward.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < NPORTS; i++) begin
            scan_idx = (RR != 0) ? ((int'(last) + 1 + i) % NPORTS) : i;
            for (int k = 0; k < NPORTS; k++) begin
                if (!found && (k == scan_idx) && m_cyc_i[k]) begin
                    found  = 1'b1;
                    winner = OW'(k);
                end
            end
        end
    end

    // Owner's signals, selected by constant slices so the mux stays static.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (owner == OW'(k)) begin
                own_cyc = m_cyc_i[k];
                own_stb = m_stb_i[k];
                own_we  = m_we_i[k];
                own_sel = m_sel_i[k*SW +: SW];
                own_adr = m_adr_i[k*AWIDTH +: AWIDTH];
                own_dat = m_dat_i[k*DWIDTH +: DWIDTH];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;

    // The counter is held at zero outside OWNED, so every new grant starts
    // from zero. It also clears on any slave response. It stops counting at
    // TIMEOUT-1 and does not wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state != OWNED) || s_ack_i || s_err_i) begin
            wd_cnt <= '0;
        end else if (own_stb && (wd_cnt != CW'(TIMEOUT - 1))) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end

    assign timeout_hit = (state == OWNED) && own_stb && !s_ack_i && !s_err_i &&
                         (wd_cnt == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            owner <= '0;
            last  <= OW'(NPORTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|m_cyc_i) begin
                        owner <= winner;
                        state <= OWNED;
                    end
                end
                OWNED: begin
                    // Releasing the bus has priority over a watchdog abort.
                    if (!own_cyc) begin
                        state <= IDLE;
                        last  <= owner;
                    end else if (timeout_hit) begin
                        state <= ABORT;
                    end
                end
                ABORT: begin
                    if (!own_cyc) begin
                        state <= IDLE;
                        last  <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave bus and terminations. Everything is quiet in IDLE and ABORT.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (state == OWNED) begin
            s_cyc_o = own_cyc;
            s_stb_o = own_stb;
            s_we_o  = own_we;
            s_sel_o = own_sel;
            s_adr_o = own_adr;
            s_dat_o = own_dat;
            for (int k = 0; k < NPORTS; k++) begin
                if (owner == OW'(k)) begin
                    m_ack_o[k] = s_ack_i;
                    m_err_o[k] = s_err_i | timeout_hit;
                end
            end
        end
    end

    assign m_dat_o = s_dat_i;
    assign owner_o = owner;
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Testbench for wb_arbiter_n. There are two instances, one per arbitration
// mode. Both share the master and slave stimulus, and use_fp selects which
// instance's outputs are observed.
module tb_wb_arbiter_n;
    localparam int NP = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    cyc = '0, stb = '0, we = '0;
    logic [NP*SW-1:0] sel = '0;
    logic [NP*AW-1:0] adr = '0;
    logic [NP*DW-1:0] dat = '0;
    logic [DW-1:0]    s_dat = '0;
    logic             s_ack = 1'b0, s_err = 1'b0;

    logic [DW-1:0] rr_mdat, fp_mdat, rr_sdat, fp_sdat;
    logic [NP-1:0] rr_ack, fp_ack, rr_err, fp_err;
    logic          rr_scyc, fp_scyc, rr_sstb, fp_sstb, rr_swe, fp_swe;
    logic [SW-1:0] rr_ssel, fp_ssel;
    logic [AW-1:0] rr_sadr, fp_sadr;
    logic [1:0]    rr_owner, fp_owner;
    logic          rr_busy, fp_busy;

    wb_arbiter_n #(.NPORTS(NP), .AWIDTH(AW), .DWIDTH(DW), .RR(1), .TIMEOUT(TO)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_sel_i(sel), .m_adr_i(adr), .m_dat_i(dat),
        .m_dat_o(rr_mdat), .m_ack_o(rr_ack), .m_err_o(rr_err),
        .s_cyc_o(rr_scyc), .s_stb_o(rr_sstb), .s_we_o(rr_swe), .s_sel_o(rr_ssel),
        .s_adr_o(rr_sadr), .s_dat_o(rr_sdat),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .owner_o(rr_owner), .busy_o(rr_busy)
    );

    wb_arbiter_n #(.NPORTS(NP), .AWIDTH(AW), .DWIDTH(DW), .RR(0), .TIMEOUT(TO)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_sel_i(sel), .m_adr_i(adr), .m_dat_i(dat),
        .m_dat_o(fp_mdat), .m_ack_o(fp_ack), .m_err_o(fp_err),
        .s_cyc_o(fp_scyc), .s_stb_o(fp_sstb), .s_we_o(fp_swe), .s_sel_o(fp_ssel),
        .s_adr_o(fp_sadr), .s_dat_o(fp_sdat),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .owner_o(fp_owner), .busy_o(fp_busy)
    );

    logic use_fp = 1'b0;
    logic [DW-1:0] o_mdat, o_sdat;
    logic [NP-1:0] o_ack, o_err;
    logic          o_scyc, o_sstb, o_swe, o_busy;
    logic [SW-1:0] o_ssel;
    logic [AW-1:0] o_sadr;
    logic [1:0]    o_owner;

    assign o_mdat  = use_fp ? fp_mdat  : rr_mdat;
    assign o_sdat  = use_fp ? fp_sdat  : rr_sdat;
    assign o_ack   = use_fp ? fp_ack   : rr_ack;
    assign o_err   = use_fp ? fp_err   : rr_err;
    assign o_scyc  = use_fp ? fp_scyc  : rr_scyc;
    assign o_sstb  = use_fp ? fp_sstb  : rr_sstb;
    assign o_swe   = use_fp ? fp_swe   : rr_swe;
    assign o_ssel  = use_fp ? fp_ssel  : rr_ssel;
    assign o_sadr  = use_fp ? fp_sadr  : rr_sadr;
    assign o_busy  = use_fp ? fp_busy  : rr_busy;
    assign o_owner = use_fp ? fp_owner : rr_owner;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cyc = '0; stb = '0; we = '0; s_ack = 1'b0; s_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_fields();
        for (int k = 0; k < NP; k++) begin
            adr[k*AW +: AW] = AW'($urandom);
            dat[k*DW +: DW] = $urandom;
            sel[k*SW +: SW] = SW'($urandom);
        end
        we = NP'($urandom);
    endtask

    // Reference arbitration rule: the first requester in the scan order.
    function automatic int pick(logic [NP-1:0] req, int last, logic fixed);
        for (int i = 1; i <= NP; i++) begin
            int p;
            p = fixed ? (i - 1) : ((last + i) % NP);
            if (req[p]) return p;
        end
        return 0;
    endfunction

    task automatic test_reset();
        use_fp = 1'b0;
        @(negedge clk);
        rst = 1'b1; cyc = '1; stb = '1; s_ack = 1'b1; rand_fields();
        @(negedge clk);
        #1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", o_busy); end
        n_checks++; if (o_owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner got=%0d want=0", o_owner); end
        n_checks++; if ({o_scyc, o_sstb, o_swe} !== 3'b000) begin n_fail++; $display("FAIL reset_sctl got=%b want=000", {o_scyc, o_sstb, o_swe}); end
        n_checks++; if (o_sadr !== '0) begin n_fail++; $display("FAIL reset_sadr got=%h want=0", o_sadr); end
        n_checks++; if ({o_ack, o_err} !== 8'h00) begin n_fail++; $display("FAIL reset_ackerr got=%b want=0", {o_ack, o_err}); end
        rst = 1'b0; cyc = '0; stb = '0; s_ack = 1'b0;
    endtask

    task automatic test_rr_order();
        use_fp = 1'b0;
        do_reset();
        @(negedge clk);
        cyc = 4'hF; stb = 4'hF; rand_fields();
        #1;
        n_checks++; if (o_scyc !== 1'b0) begin n_fail++; $display("FAIL rr_latency s_cyc got=%b want=0", o_scyc); end
        for (int p = 0; p < NP; p++) begin
            @(negedge clk);
            s_ack = 1'b1;
            #1;
            n_checks++; if (o_owner !== 2'(p)) begin n_fail++; $display("FAIL rr_owner got=%0d want=%0d", o_owner, p); end
            n_checks++; if ({o_busy, o_scyc} !== 2'b11) begin n_fail++; $display("FAIL rr_grant busy/cyc got=%b want=11", {o_busy, o_scyc}); end
            n_checks++; if (o_ack !== NP'(1 << p)) begin n_fail++; $display("FAIL rr_ack got=%b want=%b", o_ack, NP'(1 << p)); end
            n_checks++; if (o_sadr !== adr[p*AW +: AW]) begin n_fail++; $display("FAIL rr_sadr got=%h want=%h", o_sadr, adr[p*AW +: AW]); end
            @(negedge clk);
            s_ack = 1'b0; cyc[p] = 1'b0; stb[p] = 1'b0;
            #1;
            n_checks++; if (o_scyc !== 1'b0) begin n_fail++; $display("FAIL rr_drop s_cyc got=%b want=0", o_scyc); end
            if (p < NP - 1) begin
                @(negedge clk);
                #1;
                n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rr_dead busy got=%b want=0", o_busy); end
            end
        end
    endtask

    task automatic test_fixed_priority();
        use_fp = 1'b1;
        do_reset();
        @(negedge clk);
        cyc = 4'b1010; stb = 4'b1010; rand_fields();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++; if (o_owner !== 2'd1 || o_busy !== 1'b1) begin n_fail++; $display("FAIL fp_hold owner=%0d busy=%b want 1/1", o_owner, o_busy); end
        end
        @(negedge clk); cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk); cyc[1] = 1'b1; stb[1] = 1'b1;
        #1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL fp_dead busy got=%b want=0", o_busy); end
        @(negedge clk); #1;
        n_checks++; if (o_owner !== 2'd1) begin n_fail++; $display("FAIL fp_rerequest owner got=%0d want=1", o_owner); end
        @(negedge clk); cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL fp_dead2 busy got=%b want=0", o_busy); end
        @(negedge clk); #1;
        n_checks++; if (o_owner !== 2'd3 || o_scyc !== 1'b1) begin n_fail++; $display("FAIL fp_port3 owner=%0d s_cyc=%b want 3/1", o_owner, o_scyc); end
        @(negedge clk); cyc = '0; stb = '0;
    endtask

    task automatic test_locked_burst();
        use_fp = 1'b0;
        do_reset();
        @(negedge clk);
        rand_fields();
        cyc = 4'b0100; stb = 4'b0100; adr[2*AW +: AW] = AW'(32'h100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cyc[0] = 1'b1; stb[0] = 1'b1; s_ack = 1'b1;
            adr[2*AW +: AW] = AW'(32'h100 + 4 * i);
            #1;
            n_checks++; if (o_owner !== 2'd2) begin n_fail++; $display("FAIL lock_owner beat=%0d got=%0d want=2", i, o_owner); end
            n_checks++; if (o_sadr !== AW'(32'h100 + 4 * i)) begin n_fail++; $display("FAIL lock_sadr got=%h want=%h", o_sadr, AW'(32'h100 + 4 * i)); end
            n_checks++; if (o_ack !== 4'b0100) begin n_fail++; $display("FAIL lock_ack got=%b want=0100", o_ack); end
        end
        @(negedge clk);
        s_ack = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
        #1;
        n_checks++; if (o_owner !== 2'd2 || o_busy !== 1'b1) begin n_fail++; $display("FAIL lock_drop owner=%0d busy=%b want 2/1", o_owner, o_busy); end
        @(negedge clk); #1;
        n_checks++; if (o_busy !== 1'b0 || o_owner !== 2'd2) begin n_fail++; $display("FAIL lock_dead busy=%b owner=%0d want 0/2", o_busy, o_owner); end
        @(negedge clk); #1;
        n_checks++; if (o_owner !== 2'd0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL lock_next owner=%0d busy=%b want 0/1", o_owner, o_busy); end
        @(negedge clk); cyc = '0; stb = '0;
    endtask

    task automatic test_reset_mid();
        use_fp = 1'b0;
        do_reset();
        @(negedge clk);
        cyc = 4'b0010; stb = 4'b0010; rand_fields();
        @(negedge clk);
        s_ack = 1'b1; rst = 1'b1;
        #1;
        n_checks++; if (o_owner !== 2'd1 || o_ack !== 4'b0010) begin n_fail++; $display("FAIL rstmid_pre owner=%0d ack=%b want 1/0010", o_owner, o_ack); end
        @(negedge clk);
        rst = 1'b0; cyc = 4'b0011; stb = 4'b0011;
        #1;
        n_checks++; if ({o_scyc, o_busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_after cyc/busy got=%b want=00", {o_scyc, o_busy}); end
        n_checks++; if (o_ack !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ack got=%b want=0000", o_ack); end
        @(negedge clk);
        s_ack = 1'b0;
        #1;
        n_checks++; if (o_owner !== 2'd0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_regrant owner=%0d busy=%b want 0/1", o_owner, o_busy); end
        @(negedge clk); cyc = '0; stb = '0;
    endtask

    task automatic test_error();
        use_fp = 1'b0;
        do_reset();
        @(negedge clk);
        rand_fields();
        cyc = 4'b0010; stb = 4'b0010; we = 4'b0000;
        @(negedge clk);
        s_dat = 32'hDEADBEEF; s_err = 1'b1; s_ack = 1'b0;
        #1;
        n_checks++; if (o_err !== 4'b0010) begin n_fail++; $display("FAIL err_mask got=%b want=0010", o_err); end
        n_checks++; if (o_mdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_mdat got=%h want=deadbeef", o_mdat); end
        n_checks++; if (o_ack !== 4'b0000) begin n_fail++; $display("FAIL err_ack got=%b want=0000", o_ack); end
        n_checks++; if (o_swe !== 1'b0) begin n_fail++; $display("FAIL err_swe got=%b want=0", o_swe); end
        @(negedge clk); s_err = 1'b0; cyc = '0; stb = '0;
    endtask

    task automatic test_timeout();
        use_fp = 1'b0;
        do_reset();
        @(negedge clk);
        rand_fields();
        cyc = 4'b0001; stb = 4'b0001; s_ack = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk); #1;
            n_checks++; if (o_scyc !== 1'b1) begin n_fail++; $display("FAIL to_stall_cyc k=%0d got=%b want=1", k, o_scyc); end
            n_checks++; if (o_err !== ((k == TO) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL to_err k=%0d got=%b want=%b", k, o_err, (k == TO) ? 4'b0001 : 4'b0000); end
        end
        @(negedge clk); #1;
        n_checks++; if ({o_scyc, o_sstb} !== 2'b00) begin n_fail++; $display("FAIL to_abort cyc/stb got=%b want=00", {o_scyc, o_sstb}); end
        n_checks++; if (o_err !== 4'b0000 || o_busy !== 1'b1) begin n_fail++; $display("FAIL to_abort err=%b busy=%b want 0000/1", o_err, o_busy); end
        @(negedge clk); cyc = '0; stb = '0;
        @(negedge clk); #1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL to_release busy got=%b want=0", o_busy); end
`else
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk); #1;
            n_checks++; if ({o_busy, o_scyc, o_err} !== 6'b110000) begin n_fail++; $display("FAIL hold k=%0d busy/cyc/err got=%b want=110000", k, {o_busy, o_scyc, o_err}); end
        end
        @(negedge clk); cyc = '0; stb = '0;
`endif
    endtask

    // Random masters doing 1..3 beat cycles against a randomly stalling slave.
    task automatic test_random(input logic fixed);
        int exp_owner, exp_last, stall;
        logic exp_busy;
        int beats [NP];
        logic [NP-1:0] ack_seen;
        logic [NP-1:0] exp_ack;
        use_fp = fixed;
        do_reset();
        exp_busy = 1'b0; exp_owner = 0; exp_last = NP - 1; stall = 0; ack_seen = '0;
        for (int k = 0; k < NP; k++) beats[k] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            // Model advance: these inputs were the ones present at the last edge.
            if (!exp_busy) begin
                if (|cyc) begin
                    exp_owner = pick(cyc, exp_last, fixed);
                    exp_busy  = 1'b1;
                end
            end else if (!cyc[exp_owner]) begin
                exp_busy = 1'b0;
                exp_last = exp_owner;
            end
            for (int k = 0; k < NP; k++) begin
                if (cyc[k] && ack_seen[k]) begin
                    beats[k] = beats[k] - 1;
                    if (beats[k] == 0) begin cyc[k] = 1'b0; stb[k] = 1'b0; end
                end else if (!cyc[k] && ($urandom_range(3) == 0)) begin
                    cyc[k] = 1'b1; stb[k] = 1'b1; beats[k] = 1 + $urandom_range(2);
                end
            end
            rand_fields();
            s_dat = $urandom;
            s_ack = (stall >= 4) ? 1'b1 : 1'($urandom_range(1));
            stall = s_ack ? 0 : stall + 1;
            #1;
            exp_ack = (exp_busy && s_ack) ? NP'(1 << exp_owner) : '0;
            ack_seen = o_ack;
            n_checks++; if (o_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, o_busy, exp_busy); end
            n_checks++; if (o_owner !== 2'(exp_owner)) begin n_fail++; $display("FAIL rnd_owner c=%0d got=%0d want=%0d", c, o_owner, exp_owner); end
            n_checks++; if (o_scyc !== (exp_busy & cyc[exp_owner])) begin n_fail++; $display("FAIL rnd_scyc c=%0d got=%b want=%b", c, o_scyc, exp_busy & cyc[exp_owner]); end
            n_checks++; if (o_sadr !== (exp_busy ? adr[exp_owner*AW +: AW] : '0)) begin n_fail++; $display("FAIL rnd_sadr c=%0d got=%h", c, o_sadr); end
            n_checks++; if (o_sdat !== (exp_busy ? dat[exp_owner*DW +: DW] : '0)) begin n_fail++; $display("FAIL rnd_sdat c=%0d got=%h", c, o_sdat); end
            n_checks++; if (o_ack !== exp_ack) begin n_fail++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, o_ack, exp_ack); end
            n_checks++; if (o_mdat !== s_dat) begin n_fail++; $display("FAIL rnd_mdat c=%0d got=%h want=%h", c, o_mdat, s_dat); end
        end
        @(negedge clk); cyc = '0; stb = '0; s_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_fixed_priority();
        test_locked_burst();
        test_reset_mid();
        test_error();
        test_timeout();
        test_random(1'b0);
        test_random(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
